display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller_if.sv | 27 ++
 rtl/display_scan_controller.sv | 171 +++++++++++++++++
 tb/tb_display_scan_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if
//   Groups the display controller's datapath-facing signals.
//   master : clock/alarm datapath side (drives digits and masks, observes the scan outputs)
//   slave  : display_scan_controller
//   Signals: enable, digits_in[15:0], blink_mask[3:0], dp_mask[3:0], lz_suppress,
//            digit_out[3:0], AN[3:0], DP, frame_start
interface display_scan_controller_if;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        lz_suppress;
    logic [3:0]  digit_out;
    logic [3:0]  AN;
    logic        DP;
    logic        frame_start;

    modport master (
        output enable, digits_in, blink_mask, dp_mask, lz_suppress,
        input  digit_out, AN, DP, frame_start
    );

    modport slave (
        input  enable, digits_in, blink_mask, dp_mask, lz_suppress,
        output digit_out, AN, DP, frame_start
    );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexes four BCD digits (HH:MM, digit 0 = rightmost) onto one shared cathode
//   decoder and four active-low anodes. Each slot is REFRESH_DIV cycles: DEAD_CYCLES with all
//   anodes off (cathodes settle), then the selected anode is lit. Inputs are snapshotted once
//   per frame; per-digit blink, decimal point and hour leading-zero blanking are applied.
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     bus    : slave modport of display_scan_controller_if
//              (enable, digits_in, blink_mask, dp_mask, lz_suppress in;
//               digit_out, AN, DP, frame_start out, all registered)
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned DEAD_CYCLES  = 16,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input logic                      clk,
    input logic                      rst_n,
    display_scan_controller_if.slave bus
);

    localparam int unsigned SW = $clog2(REFRESH_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    BLANK      = 4'd10;

    typedef enum logic [1:0] {StIdle, StDead, StOn} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [FW-1:0] frame_q, frame_d;
    logic        phase_q, phase_d;
    logic [15:0] snap_digits_q, snap_digits_d;
    logic [3:0]  snap_blink_q, snap_blink_d;
    logic [3:0]  snap_dp_q, snap_dp_d;
    logic        snap_lz_q, snap_lz_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  digit_q, digit_d;
    logic        dp_q, dp_d;
    logic        fs_q, fs_d;
    logic        take;
    logic        advance;
    logic [3:0]  nibble;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        slot_d        = slot_q;
        frame_d       = frame_q;
        phase_d       = phase_q;
        snap_digits_d = snap_digits_q;
        snap_blink_d  = snap_blink_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        fs_d          = 1'b0;
        take          = 1'b0;
        advance       = 1'b0;

        if (!bus.enable) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            slot_d  = '0;
            frame_d = '0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StDead;
                    idx_d   = 2'd0;
                    slot_d  = '0;
                    take    = 1'b1;
                end
                StDead: begin
                    slot_d = slot_q + SW'(1);
                    if (slot_q == DEAD_LAST) state_d = StOn;
                end
                StOn: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = StDead;
                        slot_d  = '0;
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            take    = 1'b1;
                            advance = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (take) begin
            snap_digits_d = bus.digits_in;
            snap_blink_d  = bus.blink_mask;
            snap_dp_d     = bus.dp_mask;
            snap_lz_d     = bus.lz_suppress;
            fs_d          = 1'b1;
            // The counter counts completed frames, so the frame started from idle is frame 0
            // and the first BLINK_FRAMES frames after enabling are visible.
            if (advance) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end
        end

        // Outputs are registered, so they are derived from next-state values; this lets the
        // cathodes show the new digit in the very first dead cycle of its slot.
        nibble  = 4'(snap_digits_d >> {idx_d, 2'b00});
        an_d    = 4'hF;
        digit_d = BLANK;
        dp_d    = 1'b1;
        if (state_d != StIdle) begin
            if (state_d == StOn) an_d = ~(4'b0001 << idx_d);
            if (!(phase_d && snap_blink_d[idx_d])) begin
                dp_d = ~snap_dp_d[idx_d];
                if ((idx_d == 2'd3 && snap_lz_d && nibble == 4'd0) || nibble > 4'd9) begin
                    digit_d = BLANK;
                end else begin
                    digit_d = nibble;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            slot_q        <= '0;
            frame_q       <= '0;
            phase_q       <= 1'b0;
            snap_digits_q <= 16'hFFFF;
            snap_blink_q  <= 4'h0;
            snap_dp_q     <= 4'h0;
            snap_lz_q     <= 1'b0;
            an_q          <= 4'hF;
            digit_q       <= BLANK;
            dp_q          <= 1'b1;
            fs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            slot_q        <= slot_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            snap_digits_q <= snap_digits_d;
            snap_blink_q  <= snap_blink_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            an_q          <= an_d;
            digit_q       <= digit_d;
            dp_q          <= dp_d;
            fs_q          <= fs_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.digit_out   = digit_q;
    assign bus.DP          = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Directed bench for display_scan_controller with REFRESH_DIV=8, DEAD_CYCLES=2,
//   BLINK_FRAMES=2 (slot = 8 cycles: 2 dark + 6 lit, frame = 32 cycles).
module tb_display_scan_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    display_scan_controller_if dif ();

    display_scan_controller #(
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the first dead cycle of a slot; returns in the first dead cycle of the next.
    task automatic run_slot(input string tag, input logic [3:0] exp_digit,
                            input logic [3:0] lit_an, input logic exp_dp, input logic exp_fs);
        check({tag, "_fs"}, 16'(dif.frame_start), 16'(exp_fs));
        check({tag, "_dead_an"}, 16'(dif.AN), 16'hF);
        check({tag, "_dead_digit"}, 16'(dif.digit_out), 16'(exp_digit));
        check({tag, "_dead_dp"}, 16'(dif.DP), 16'(exp_dp));
        tick();
        check({tag, "_dead2_an"}, 16'(dif.AN), 16'hF);
        check({tag, "_dead2_fs"}, 16'(dif.frame_start), 16'h0);
        tick();
        check({tag, "_on_an"}, 16'(dif.AN), 16'(lit_an));
        check({tag, "_on_digit"}, 16'(dif.digit_out), 16'(exp_digit));
        check({tag, "_on_dp"}, 16'(dif.DP), 16'(exp_dp));
        repeat (5) tick();
        check({tag, "_end_an"}, 16'(dif.AN), 16'(lit_an));
        tick();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        dif.enable      = 1'b0;
        dif.digits_in   = 16'h0000;
        dif.blink_mask  = 4'h0;
        dif.dp_mask     = 4'h0;
        dif.lz_suppress = 1'b0;
        #12;
        check("rst_an", 16'(dif.AN), 16'hF);
        check("rst_digit", 16'(dif.digit_out), 16'hA);
        check("rst_dp", 16'(dif.DP), 16'h1);
        check("rst_fs", 16'(dif.frame_start), 16'h0);
        rst_n = 1'b1;
        tick();
        check("idle_an", 16'(dif.AN), 16'hF);

        // Scan order
        dif.digits_in = 16'h1234;
        dif.enable    = 1'b1;
        tick();
        run_slot("f0s0", 4'd4, 4'b1110, 1'b1, 1'b1);
        run_slot("f0s1", 4'd3, 4'b1101, 1'b1, 1'b0);
        run_slot("f0s2", 4'd2, 4'b1011, 1'b1, 1'b0);
        run_slot("f0s3", 4'd1, 4'b0111, 1'b1, 1'b0);

        // Snapshot tearing: change digits during slot 1
        run_slot("f1s0", 4'd4, 4'b1110, 1'b1, 1'b1);
        dif.digits_in = 16'h5678;
        run_slot("f1s1", 4'd3, 4'b1101, 1'b1, 1'b0);
        run_slot("f1s2", 4'd2, 4'b1011, 1'b1, 1'b0);
        run_slot("f1s3", 4'd1, 4'b0111, 1'b1, 1'b0);
        run_slot("f2s0", 4'd8, 4'b1110, 1'b1, 1'b1);
        run_slot("f2s1", 4'd7, 4'b1101, 1'b1, 1'b0);
        run_slot("f2s2", 4'd6, 4'b1011, 1'b1, 1'b0);
        run_slot("f2s3", 4'd5, 4'b0111, 1'b1, 1'b0);

        // Disable during ON
        tick();
        tick();
        check("pre_dis_an", 16'(dif.AN), 16'hE);
        dif.enable = 1'b0;
        tick();
        check("dis_an", 16'(dif.AN), 16'hF);
        check("dis_digit", 16'(dif.digit_out), 16'hA);
        check("dis_fs", 16'(dif.frame_start), 16'h0);
        tick();
        check("dis2_an", 16'(dif.AN), 16'hF);

        // Re-enable with blink on digits 2 and 3
        dif.digits_in  = 16'h1234;
        dif.blink_mask = 4'b1100;
        dif.enable     = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) begin
            logic blank;
            blank = (f == 2) || (f == 3);
            run_slot($sformatf("b%0ds0", f), 4'd4, 4'b1110, 1'b1, 1'b1);
            run_slot($sformatf("b%0ds1", f), 4'd3, 4'b1101, 1'b1, 1'b0);
            run_slot($sformatf("b%0ds2", f), blank ? 4'd10 : 4'd2, 4'b1011, 1'b1, 1'b0);
            if (f == 4) begin
                dif.digits_in   = 16'h0A59;
                dif.lz_suppress = 1'b1;
                dif.dp_mask     = 4'b0100;
                dif.blink_mask  = 4'b0000;
            end
            run_slot($sformatf("b%0ds3", f), blank ? 4'd10 : 4'd1, 4'b0111, 1'b1, 1'b0);
        end

        // Leading zero, invalid nibble and decimal point
        run_slot("lz_s0", 4'd9, 4'b1110, 1'b1, 1'b1);
        run_slot("lz_s1", 4'd5, 4'b1101, 1'b1, 1'b0);
        run_slot("lz_s2", 4'd10, 4'b1011, 1'b0, 1'b0);
        run_slot("lz_s3", 4'd10, 4'b0111, 1'b1, 1'b0);

        // Asynchronous reset mid-ON
        repeat (3) tick();
        check("pre_rst_an", 16'(dif.AN), 16'hE);
        rst_n = 1'b0;
        #1;
        check("arst_an", 16'(dif.AN), 16'hF);
        check("arst_digit", 16'(dif.digit_out), 16'hA);
        check("arst_dp", 16'(dif.DP), 16'h1);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
